bus_load_decoder: RTL and testbench

Destination side of the datapath's shared 32-bit bus. It decodes a 5-bit destination code, using the same numbering the bus source select uses, into one-hot load enables. It then captures the bus value into the addressed register: R0–R15, HI, LO or PC. Stored values are presented back as the register inputs of the bus source mux, with R0 gating for base-address use and a PC incrementer.

---
 rtl/bus_load_decoder.sv | 123 ++++++++++++
 tb/tb_bus_load_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bus_load_decoder.sv
// Destination side of the shared datapath bus: decodes the destination code into
// one-hot load enables and captures the bus into R0-R15, HI, LO or PC.
module bus_load_decoder #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PC_STEP = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic [4:0]       dest,
  input  logic             load,
  input  logic             pc_inc,
  input  logic             BAout,
  output logic [23:0]      Rin,
  output logic [WIDTH-1:0] R0_q,
  output logic [WIDTH-1:0] R1_q,
  output logic [WIDTH-1:0] R2_q,
  output logic [WIDTH-1:0] R3_q,
  output logic [WIDTH-1:0] R4_q,
  output logic [WIDTH-1:0] R5_q,
  output logic [WIDTH-1:0] R6_q,
  output logic [WIDTH-1:0] R7_q,
  output logic [WIDTH-1:0] R8_q,
  output logic [WIDTH-1:0] R9_q,
  output logic [WIDTH-1:0] R10_q,
  output logic [WIDTH-1:0] R11_q,
  output logic [WIDTH-1:0] R12_q,
  output logic [WIDTH-1:0] R13_q,
  output logic [WIDTH-1:0] R14_q,
  output logic [WIDTH-1:0] R15_q,
  output logic [WIDTH-1:0] R0_bus,
  output logic [WIDTH-1:0] HI_q,
  output logic [WIDTH-1:0] LO_q,
  output logic [WIDTH-1:0] PC_q,
  output logic             err
);

  localparam int unsigned DEST_W  = 5;
  localparam int unsigned NUM_EN  = 24;
  localparam int unsigned NUM_GPR = 16;
  localparam int unsigned CODE_HI = 16;
  localparam int unsigned CODE_LO = 17;
  localparam int unsigned CODE_PC = 20;

  logic             writable;
  logic [WIDTH-1:0] gpr_q [NUM_GPR];
  logic [WIDTH-1:0] gpr_d [NUM_GPR];
  logic [WIDTH-1:0] hi_val_q, hi_val_d;
  logic [WIDTH-1:0] lo_val_q, lo_val_d;
  logic [WIDTH-1:0] pc_val_q, pc_val_d;
  logic             err_q, err_d;

  // Codes 18, 19 and 21-31 have no backing register.
  always_comb begin
    writable = (dest <= DEST_W'(CODE_LO)) || (dest == DEST_W'(CODE_PC));
  end

  always_comb begin
    Rin = '0;
    for (int n = 0; n < int'(NUM_EN); n++) begin
      Rin[n] = load & ~clear & writable & (dest == DEST_W'(n));
    end
  end

  always_comb begin
    for (int n = 0; n < int'(NUM_GPR); n++) begin
      gpr_d[n] = Rin[n] ? BusMuxOut : gpr_q[n];
    end
    hi_val_d = Rin[CODE_HI] ? BusMuxOut : hi_val_q;
    lo_val_d = Rin[CODE_LO] ? BusMuxOut : lo_val_q;
    // A bus load to PC wins over the incrementer on the same edge.
    pc_val_d = pc_val_q;
    if (Rin[CODE_PC]) begin
      pc_val_d = BusMuxOut;
    end else if (pc_inc) begin
      pc_val_d = pc_val_q + WIDTH'(PC_STEP);
    end
    err_d = err_q | (load & ~writable);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int n = 0; n < int'(NUM_GPR); n++) begin
        gpr_q[n] <= '0;
      end
      hi_val_q <= '0;
      lo_val_q <= '0;
      pc_val_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int n = 0; n < int'(NUM_GPR); n++) begin
        gpr_q[n] <= gpr_d[n];
      end
      hi_val_q <= hi_val_d;
      lo_val_q <= lo_val_d;
      pc_val_q <= pc_val_d;
      err_q    <= err_d;
    end
  end

  assign R0_q   = gpr_q[0];
  assign R1_q   = gpr_q[1];
  assign R2_q   = gpr_q[2];
  assign R3_q   = gpr_q[3];
  assign R4_q   = gpr_q[4];
  assign R5_q   = gpr_q[5];
  assign R6_q   = gpr_q[6];
  assign R7_q   = gpr_q[7];
  assign R8_q   = gpr_q[8];
  assign R9_q   = gpr_q[9];
  assign R10_q  = gpr_q[10];
  assign R11_q  = gpr_q[11];
  assign R12_q  = gpr_q[12];
  assign R13_q  = gpr_q[13];
  assign R14_q  = gpr_q[14];
  assign R15_q  = gpr_q[15];
  assign R0_bus = BAout ? '0 : gpr_q[0];
  assign HI_q   = hi_val_q;
  assign LO_q   = lo_val_q;
  assign PC_q   = pc_val_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bus_load_decoder.sv
// Directed bench for bus_load_decoder: a register-file model checked every cycle
// plus literal expectations at the key points of each scenario.
module tb_bus_load_decoder;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic [4:0]  dest;
  logic        load, pc_inc, BAout;
  logic [23:0] Rin;
  logic [31:0] r_q [16];
  logic [31:0] R0_bus, HI_q, LO_q, PC_q;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  // Model indexed by destination code; 16=HI, 17=LO, 20=PC.
  logic [31:0] m_reg [0:20];
  bit          m_err;

  always #5 clock = ~clock;

  bus_load_decoder #(.WIDTH(32), .PC_STEP(1)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .dest(dest),
    .load(load), .pc_inc(pc_inc), .BAout(BAout), .Rin(Rin),
    .R0_q(r_q[0]), .R1_q(r_q[1]), .R2_q(r_q[2]), .R3_q(r_q[3]),
    .R4_q(r_q[4]), .R5_q(r_q[5]), .R6_q(r_q[6]), .R7_q(r_q[7]),
    .R8_q(r_q[8]), .R9_q(r_q[9]), .R10_q(r_q[10]), .R11_q(r_q[11]),
    .R12_q(r_q[12]), .R13_q(r_q[13]), .R14_q(r_q[14]), .R15_q(r_q[15]),
    .R0_bus(R0_bus), .HI_q(HI_q), .LO_q(LO_q), .PC_q(PC_q), .err(err)
  );

  function automatic bit legal(input logic [4:0] d);
    return (d <= 5'd17) || (d == 5'd20);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i <= 20; i++) m_reg[i] = '0;
      m_err = 1'b0;
    end else begin
      if (load) begin
        if (legal(dest)) m_reg[dest] = BusMuxOut;
        else m_err = 1'b1;
      end
      if (pc_inc && !(load && dest == 5'd20)) m_reg[20] = m_reg[20] + 32'd1;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      logic [23:0] exp_rin;
      exp_rin = (load && !clear && legal(dest)) ? (24'd1 << dest) : 24'd0;
      for (int i = 0; i < 16; i++) chk($sformatf("R%0d_q", i), r_q[i], m_reg[i]);
      chk("HI_q", HI_q, m_reg[16]);
      chk("LO_q", LO_q, m_reg[17]);
      chk("PC_q", PC_q, m_reg[20]);
      chk("err", 32'(err), 32'(m_err));
      chk("Rin", 32'(Rin), 32'(exp_rin));
      chk("R0_bus", R0_bus, BAout ? 32'd0 : m_reg[0]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1; BusMuxOut = '0; dest = '0; load = 1'b0; pc_inc = 1'b0; BAout = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    clear = 1'b0;
    chk("reset PC_q", PC_q, 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset R0_bus", R0_bus, 32'd0);

    // Single write to R5
    load = 1'b1; dest = 5'd5; BusMuxOut = 32'hA5A5_0001;
    #1 chk("Rin dest5", 32'(Rin), 32'h0000_0020);
    tick();
    load = 1'b0;
    chk("R5 written", r_q[5], 32'hA5A5_0001);
    chk("R4 untouched", r_q[4], 32'd0);

    // R0 storage vs. base-address gating
    load = 1'b1; dest = 5'd0; BusMuxOut = 32'h0000_1234;
    tick();
    load = 1'b0; BAout = 1'b1;
    #1 chk("R0_q with BAout", r_q[0], 32'h0000_1234);
    chk("R0_bus gated", R0_bus, 32'd0);
    BAout = 1'b0;
    #1 chk("R0_bus open", R0_bus, 32'h0000_1234);
    tick();

    // PC wrap and load-over-increment priority
    load = 1'b1; dest = 5'd20; BusMuxOut = 32'hFFFF_FFFF;
    tick();
    load = 1'b0; pc_inc = 1'b1;
    tick();
    chk("PC wrap", PC_q, 32'd0);
    tick();
    chk("PC inc", PC_q, 32'd1);
    load = 1'b1; dest = 5'd20; BusMuxOut = 32'h40;
    tick();
    load = 1'b0; pc_inc = 1'b0;
    chk("PC load wins", PC_q, 32'h40);

    // Illegal destination
    load = 1'b1; dest = 5'd19; BusMuxOut = 32'hDEAD_BEEF;
    #1 chk("Rin illegal", 32'(Rin), 32'd0);
    tick();
    load = 1'b0;
    chk("err set", 32'(err), 32'd1);
    chk("R5 after illegal", r_q[5], 32'hA5A5_0001);
    tick();
    chk("err sticky", 32'(err), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("err cleared", 32'(err), 32'd0);
    chk("R5 cleared", r_q[5], 32'd0);

    // HI/LO loads with concurrent PC increment
    pc_inc = 1'b1; load = 1'b1; dest = 5'd16; BusMuxOut = 32'h1;
    tick();
    dest = 5'd17; BusMuxOut = 32'h2;
    tick();
    load = 1'b0; pc_inc = 1'b0;
    chk("HI_q", HI_q, 32'h1);
    chk("LO_q", LO_q, 32'h2);
    chk("PC after incs", PC_q, 32'h2);

    // Clear beats a simultaneous load; load accepted once clear drops
    clear = 1'b1; load = 1'b1; dest = 5'd3; BusMuxOut = 32'hFFFF_FFFF;
    #1 chk("Rin under clear", 32'(Rin), 32'd0);
    tick();
    chk("R3 under clear", r_q[3], 32'd0);
    clear = 1'b0;
    tick();
    load = 1'b0;
    chk("R3 after clear", r_q[3], 32'hFFFF_FFFF);

    // Held load rewrites the same register each edge
    load = 1'b1; dest = 5'd7;
    for (int k = 1; k <= 3; k++) begin
      BusMuxOut = 32'h100 * 32'(k);
      tick();
    end
    load = 1'b0;
    chk("R7 held load", r_q[7], 32'h300);

    // Sweep every destination code; model covers legal and illegal codes
    for (int c = 0; c < 32; c++) begin
      load = 1'b1; dest = 5'(c); BusMuxOut = 32'h0101_0101 * 32'(c + 1);
      tick();
    end
    load = 1'b0;
    chk("R15 sweep", r_q[15], 32'h1010_1010);
    chk("err sweep", 32'(err), 32'd1);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
